// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges pipeline and long-latency writeback onto one regfile port with a busy scoreboard
module regfile_wb_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [WIDTH-1:0]         wb_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [WIDTH-1:0]         lu_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  input  logic [4:0]               chk_rd,
  output logic                     stall,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [WIDTH-1:0]         wd3,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [31:0]      busy, busy_nxt, clr, set;
  logic             pipe_wr, drain, byp, byp_wr, lu_wr, push;
  // write-port arbitration: pipeline first, then FIFO head, then bypass of the incoming result
  always_comb begin
    pipe_wr  = rst_n && wb_we && wb_rd != 5'd0;
    drain    = rst_n && !pipe_wr && fifo_cnt != '0;
    lu_ready = rst_n && fifo_cnt != (AW+1)'(DEPTH);
    byp      = lu_valid && lu_ready && !pipe_wr && fifo_cnt == '0;
    byp_wr   = byp && lu_rd != 5'd0;
    push     = lu_valid && lu_ready && !byp && lu_rd != 5'd0;
    lu_wr    = drain || byp_wr;
    we3      = pipe_wr || lu_wr;
    wa3      = pipe_wr ? wb_rd : drain ? rd_q[rp] : byp_wr ? lu_rd : 5'd0;
    wd3      = pipe_wr ? wb_data : drain ? data_q[rp] : byp_wr ? lu_data : '0;
  end
  // scoreboard update: long-latency writes clear, issues set, set wins, x0 never busy
  always_comb begin
    clr      = lu_wr ? (32'd1 << wa3) : 32'd0;
    set      = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
    busy_nxt = ((busy & ~clr) | set) & ~32'd1;
    stall    = rst_n && (busy[ra1] | busy[ra2] | busy[chk_rd]);
  end
  // FIFO storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk)
    if (push) begin
      rd_q[wp]   <= lu_rd;
      data_q[wp] <= lu_data;
    end
  // pointers, count and busy bits; reset discards everything pending
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      fifo_cnt <= '0;
      busy     <= '0;
    end else begin
      wp       <= wp + AW'(push);
      rp       <= rp + AW'(drain);
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(drain);
      busy     <= busy_nxt;
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus hand sequences for the writeback controller
module tb_regfile_wb_ctrl;
  logic        clk, rst_n, wb_we, lu_valid, lu_ready, iss_valid, stall, we3;
  logic [4:0]  wb_rd, lu_rd, iss_rd, ra1, ra2, chk_rd, wa3;
  logic [31:0] wb_data, lu_data, wd3;
  logic [2:0]  fifo_cnt;
  int          tests, fails;
  typedef struct {
    logic        rst_n, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd, ra1, ra2, chk_rd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy, e_stall;
    logic [2:0]  e_cnt;
  } vec_t;
  vec_t vecs[31];
  regfile_wb_ctrl #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .ra1(ra1), .ra2(ra2), .chk_rd(chk_rd),
    .stall(stall), .we3(we3), .wa3(wa3), .wd3(wd3), .fifo_cnt(fifo_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t v(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                             input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                             input logic iv, input logic [4:0] ir, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] cr, input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                             input logic erdy, input logic est, input logic [2:0] ecnt);
    vec_t t;
    t.rst_n = r; t.wb_we = we; t.wb_rd = wr; t.wb_data = wd; t.lu_valid = lv; t.lu_rd = lr; t.lu_data = ld;
    t.iss_valid = iv; t.iss_rd = ir; t.ra1 = a1; t.ra2 = a2; t.chk_rd = cr;
    t.e_we = ewe; t.e_wa = ewa; t.e_wd = ewd; t.e_rdy = erdy; t.e_stall = est; t.e_cnt = ecnt;
    return t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    rst_n = t.rst_n; wb_we = t.wb_we; wb_rd = t.wb_rd; wb_data = t.wb_data;
    lu_valid = t.lu_valid; lu_rd = t.lu_rd; lu_data = t.lu_data;
    iss_valid = t.iss_valid; iss_rd = t.iss_rd; ra1 = t.ra1; ra2 = t.ra2; chk_rd = t.chk_rd;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    //             rst we rd  wb_data  lv rd  lu_data        iv ird ra1 ra2 chk | we wa  wd            rdy st cnt
    vecs[0]  = v(0, 1, 3,  32'h1,    1, 5,  32'h11,        0, 0,  5,  0,  0,    0, 0,  32'h0,        0, 0, 0);
    vecs[1]  = v(1, 0, 0,  32'h0,    1, 5,  32'hDEAD_BEEF, 0, 0,  5,  0,  0,    1, 5,  32'hDEAD_BEEF, 1, 0, 0);
    vecs[2]  = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  5,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    vecs[3]  = v(1, 1, 1,  32'h100,  1, 10, 32'hA0,        0, 0,  0,  0,  0,    1, 1,  32'h100,      1, 0, 0);
    vecs[4]  = v(1, 1, 2,  32'h200,  1, 11, 32'hA1,        0, 0,  0,  0,  0,    1, 2,  32'h200,      1, 0, 1);
    vecs[5]  = v(1, 1, 3,  32'h300,  1, 12, 32'hA2,        0, 0,  0,  0,  0,    1, 3,  32'h300,      1, 0, 2);
    vecs[6]  = v(1, 1, 4,  32'h400,  1, 13, 32'hA3,        0, 0,  0,  0,  0,    1, 4,  32'h400,      1, 0, 3);
    vecs[7]  = v(1, 1, 6,  32'h600,  1, 14, 32'hA4,        0, 0,  0,  0,  0,    1, 6,  32'h600,      0, 0, 4);
    vecs[8]  = v(1, 0, 0,  32'h0,    1, 14, 32'hA4,        0, 0,  0,  0,  0,    1, 10, 32'hA0,       0, 0, 4);
    vecs[9]  = v(1, 0, 0,  32'h0,    1, 14, 32'hA4,        0, 0,  0,  0,  0,    1, 11, 32'hA1,       1, 0, 3);
    vecs[10] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  0,    1, 12, 32'hA2,       1, 0, 3);
    vecs[11] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  0,    1, 13, 32'hA3,       1, 0, 2);
    vecs[12] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  0,    1, 14, 32'hA4,       1, 0, 1);
    vecs[13] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    vecs[14] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         1, 7,  7,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    vecs[15] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  7,  0,    0, 0,  32'h0,        1, 1, 0);
    vecs[16] = v(1, 0, 0,  32'h0,    1, 7,  32'h77,        0, 0,  7,  0,  0,    1, 7,  32'h77,       1, 1, 0);
    vecs[17] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  7,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    vecs[18] = v(1, 1, 2,  32'h22,   1, 9,  32'h99,        1, 9,  0,  0,  9,    1, 2,  32'h22,       1, 0, 0);
    vecs[19] = v(1, 1, 3,  32'h33,   1, 8,  32'h88,        0, 0,  0,  0,  9,    1, 3,  32'h33,       1, 1, 1);
    vecs[20] = v(1, 0, 0,  32'h0,    1, 20, 32'h2020,      1, 9,  0,  0,  9,    1, 9,  32'h99,       1, 1, 2);
    vecs[21] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  9,    1, 8,  32'h88,       1, 1, 2);
    vecs[22] = v(1, 1, 0,  32'h5555, 0, 0,  32'h0,         0, 0,  0,  0,  9,    1, 20, 32'h2020,     1, 1, 1);
    vecs[23] = v(1, 1, 1,  32'h1,    1, 21, 32'h21,        0, 0,  0,  0,  0,    1, 1,  32'h1,        1, 0, 0);
    vecs[24] = v(1, 1, 1,  32'h2,    1, 22, 32'h22,        0, 0,  0,  0,  0,    1, 1,  32'h2,        1, 0, 1);
    vecs[25] = v(1, 1, 1,  32'h3,    1, 23, 32'h23,        0, 0,  0,  0,  0,    1, 1,  32'h3,        1, 0, 2);
    vecs[26] = v(1, 1, 1,  32'h4,    1, 0,  32'hBAD,       1, 12, 0,  0,  0,    1, 1,  32'h4,        1, 0, 3);
    vecs[27] = v(0, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  9,    0, 0,  32'h0,        0, 0, 3);
    vecs[28] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  12, 0,  9,    0, 0,  32'h0,        1, 0, 0);
    vecs[29] = v(1, 0, 0,  32'h0,    1, 0,  32'h123,       1, 0,  0,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    vecs[30] = v(1, 0, 0,  32'h0,    0, 0,  32'h0,         0, 0,  0,  0,  0,    0, 0,  32'h0,        1, 0, 0);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 31; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), {23'd0, we3, wa3, wd3, lu_ready, stall, fifo_cnt},
          {23'd0, vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_rdy, vecs[i].e_stall, vecs[i].e_cnt});
      @(posedge clk);
      #1;
    end
    iss_valid = 1'b1; iss_rd = 5'd15; chk_rd = 5'd15;
    #1;
    chk("waw_before_issue", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    #1;
    chk("waw_stall", 64'(stall), 64'd1);
    wb_we = 1'b1; wb_rd = 5'd15; wb_data = 32'hF00D;
    #1;
    chk("pipe_write_15", {59'd0, we3, wa3}, {59'd0, 1'b1, 5'd15});
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    #1;
    chk("pipe_no_clear", 64'(stall), 64'd1);
    rst_n = 1'b0; lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_reset", {60'd0, we3, lu_ready, fifo_cnt == 3'd0, stall}, {60'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1; lu_valid = 1'b0;
    #1;
    chk("reset_clears_busy", 64'(stall), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
